// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the instruction trace buffer
package trace_pkg;

  localparam int TRACE_XLEN = 32;

  localparam logic TRACE_FILL_ONCE = 1'b0;
  localparam logic TRACE_CIRCULAR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd_sel;
    logic [TRACE_XLEN-1:0] rd_data;
  } trace_rec_t;

  function automatic int rec_w(input int xlen);
    return 2 * xlen + 37;
  endfunction

  localparam int REC_W = rec_w(TRACE_XLEN);

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace record storage: one synchronous write port, one asynchronous read port
module trace_ram #(
  parameter int W     = 101,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_trace_buffer.sv
// rtl/instr_trace_buffer.sv - retired-instruction trace capture with fill-once and PC-triggered modes
module instr_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm,
  input  logic            mode,
  input  logic            trig_pc_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [31:0]     ret_instr,
  input  logic [4:0]      ret_rd_sel,
  input  logic [XLEN-1:0] ret_rd_data,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr,
  output logic [4:0]      rd_rd_sel,
  output logic [XLEN-1:0] rd_rd_data,
  output logic [CW-1:0]   count,
  output logic [1:0]      state,
  output logic            triggered,
  output logic            wrapped
);

  localparam int RW = rec_w(XLEN);

  trace_state_t  state_q, state_d;
  logic          mode_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] post_cnt;
  logic          wr_en, trig_hit, pop, ring_full;
  logic [RW-1:0] wdata, rdata;

  assign ring_full = (count == CW'(DEPTH));
  assign wr_en     = !arm && ret_valid && (state_q == ARMED || state_q == POST);
  assign trig_hit  = !arm && ret_valid && trig_pc_en && (ret_pc == trig_pc)
                   && state_q == ARMED && mode_q == TRACE_CIRCULAR;
  assign rd_valid  = (state_q == FROZEN) && (count != '0);
  assign pop       = !arm && rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (ret_valid && mode_q == TRACE_FILL_ONCE) begin
            if (count == CW'(DEPTH - 1)) state_d = FROZEN;
          end else if (trig_hit) begin
            state_d = (POST_TRIG == 0) ? FROZEN : POST;
          end
        end
        POST: begin
          if (ret_valid && post_cnt == CW'(1)) state_d = FROZEN;
        end
        default: ;
      endcase
    end
  end

  // In circular mode a full ring drops its oldest record to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= TRACE_FILL_ONCE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
    end else if (arm) begin
      mode_q    <= mode;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (mode_q == TRACE_CIRCULAR && ring_full) begin
          rd_ptr  <= rd_ptr + 1'b1;
          wrapped <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (trig_hit) begin
        triggered <= 1'b1;
        post_cnt  <= CW'(POST_TRIG);
      end else if (wr_en && state_q == POST) begin
        post_cnt <= post_cnt - 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  assign wdata = {ret_pc, ret_instr, ret_rd_sel, ret_rd_data};

  trace_ram #(.W(RW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Record fields are forced to zero when nothing is presented, so uninitialised RAM never shows.
  assign rd_pc      = rd_valid ? rdata[RW-1 -: XLEN]        : '0;
  assign rd_instr   = rd_valid ? rdata[XLEN+36 -: 32]       : '0;
  assign rd_rd_sel  = rd_valid ? rdata[XLEN+4 -: 5]         : '0;
  assign rd_rd_data = rd_valid ? rdata[XLEN-1:0]            : '0;
  assign state      = state_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// tb/tb_instr_trace_buffer.sv - scoreboard bench for instr_trace_buffer
module tb_instr_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        arm = 1'b0, mode = 1'b0, trig_pc_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0, ret_instr = '0, ret_rd_data = '0;
  logic [4:0]  ret_rd_sel = '0;
  logic        rd_ready = 1'b0;

  logic        rd_valid, triggered, wrapped;
  logic [31:0] rd_pc, rd_instr, rd_rd_data;
  logic [4:0]  rd_rd_sel, count;
  logic [1:0]  state;

  logic        z_valid, z_triggered, z_wrapped;
  logic [31:0] z_pc, z_instr, z_data;
  logic [4:0]  z_sel, z_count;
  logic [1:0]  z_state;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .mode(mode), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd_sel(ret_rd_sel), .ret_rd_data(ret_rd_data), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_rd_sel(rd_rd_sel),
    .rd_rd_data(rd_rd_data), .count(count), .state(state), .triggered(triggered),
    .wrapped(wrapped)
  );

  instr_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .mode(mode), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd_sel(ret_rd_sel), .ret_rd_data(ret_rd_data), .rd_ready(rd_ready),
    .rd_valid(z_valid), .rd_pc(z_pc), .rd_instr(z_instr), .rd_rd_sel(z_sel),
    .rd_rd_data(z_data), .count(z_count), .state(z_state), .triggered(z_triggered),
    .wrapped(z_wrapped)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [4:0] sel_of(input logic [31:0] pc);
    return pc[6:2];
  endfunction
  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return pc + 32'h1000;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every accepted record is compared against the queue head.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      logic [31:0] e;
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got pc=%h want none", rd_pc);
      end else begin
        e = exp_q.pop_front();
        if (rd_pc !== e || rd_instr !== instr_of(e) || rd_rd_sel !== sel_of(e)
            || rd_rd_data !== data_of(e)) begin
          errors++;
          $display("FAIL drain_rec got pc=%h instr=%h sel=%0d data=%h want pc=%h instr=%h sel=%0d data=%h",
                   rd_pc, rd_instr, rd_rd_sel, rd_rd_data, e, instr_of(e), sel_of(e), data_of(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic en, input logic [31:0] tpc);
    arm = 1'b1; mode = m; trig_pc_en = en; trig_pc = tpc;
    step();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc);
    ret_valid = 1'b1; ret_pc = pc; ret_instr = instr_of(pc);
    ret_rd_sel = sel_of(pc); ret_rd_data = data_of(pc);
    step();
    ret_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    rd_ready = 1'b1;
    for (int i = 0; i < budget && rd_valid; i++) step();
    rd_ready = 1'b0;
    check({name, "_valid_low"}, rd_valid, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_pc", rd_pc, 0);
    check("rst_flags", {triggered, wrapped}, 0);
    check("rst_z_state", z_state, 0);
    rst_n = 1'b1;
    step();

    // Fill-once: freezes after the 16th of 20 retires.
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 4 * i);
    do_arm(1'b0, 1'b0, '0);
    check("arm_state", state, 1);
    for (int i = 0; i < 20; i++) retire(32'h100 + 4 * i);
    check("m0_state", state, 3);
    check("m0_count", count, 16);
    check("m0_flags", {triggered, wrapped}, 0);
    drain("m0", 40);

    // Circular with trigger at 0x200, four post records.
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h1D4 + 4 * i);
    do_arm(1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 40; i++) retire(32'h180 + 4 * i);
    check("m1_state", state, 3);
    check("m1_count", count, 16);
    check("m1_triggered", triggered, 1);
    check("m1_wrapped", wrapped, 1);
    drain("m1", 40);

    // Zero post-trigger depth: the trigger record alone freezes the capture.
    do_arm(1'b1, 1'b1, 32'h500);
    retire(32'h500);
    check("pt0_state", z_state, 3);
    check("pt0_count", z_count, 1);
    check("pt0_valid", z_valid, 1);
    check("pt0_pc", z_pc, 32'h500);
    check("pt0_main_state", state, 2);

    // Re-arm during POST with a coincident retire.
    do_arm(1'b1, 1'b1, 32'h300);
    retire(32'h2F8); retire(32'h2FC); retire(32'h300); retire(32'h304);
    check("post_state", state, 2);
    arm = 1'b1; mode = 1'b1; trig_pc = 32'h400;
    ret_valid = 1'b1; ret_pc = 32'h308; ret_instr = instr_of(32'h308);
    ret_rd_sel = sel_of(32'h308); ret_rd_data = data_of(32'h308);
    step();
    arm = 1'b0; ret_valid = 1'b0;
    check("rearm_state", state, 1);
    check("rearm_count", count, 0);
    check("rearm_flags", {triggered, wrapped}, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h400 + 4 * i);
    for (int i = 0; i < 5; i++) retire(32'h400 + 4 * i);
    check("rearm_frozen", state, 3);
    check("rearm_count5", count, 5);
    drain("rearm", 20);

    // Half-rate consumer on 8 remaining records.
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h600 + 4 * i);
    do_arm(1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) retire(32'h600 + 4 * i);
    rd_ready = 1'b1;
    repeat (8) step();
    rd_ready = 1'b0;
    check("half_count8", count, 8);
    begin
      int p0;
      p0 = pops;
      for (int i = 0; i < 16; i++) begin
        rd_ready = (i % 2 == 0);
        step();
      end
      rd_ready = 1'b0;
      check("half_pops", pops - p0, 8);
    end
    check("half_valid", rd_valid, 0);
    check("half_count0", count, 0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h700 + 4 * i);
    do_arm(1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) retire(32'h700 + 4 * i);
    rd_ready = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_count", count, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_pc", rd_pc, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    rd_ready = 1'b0;
    check("arst_after_state", state, 0);
    check("arst_after_count", count, 0);
    check("arst_after_valid", rd_valid, 0);
    check("arst_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
